// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: EX, data-memory and WB signal bundle for mem_stage_hs (misalign_m only with MEM_MISALIGN_TRAP_EN)
interface mem_stage_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W = 5
);
  logic in_valid, in_ready, reg_write_e, mem_read_e, mem_write_e, mem_unsigned_e;
  logic [1:0] mem_size_e;
  logic [DATA_W-1:0] alu_out_e, write_data_e;
  logic [REG_W-1:0] write_reg_e;
  logic dmem_req, dmem_we, dmem_ack;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic [DATA_W/8-1:0] dmem_be;
  logic out_valid, reg_write_m, timeout_m;
  logic [DATA_W-1:0] result_m;
  logic [REG_W-1:0] write_reg_m;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_m;
`endif
  modport slave (
    input in_valid, reg_write_e, mem_read_e, mem_write_e, mem_unsigned_e, mem_size_e,
          alu_out_e, write_data_e, write_reg_e, dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           out_valid, reg_write_m, timeout_m, result_m, write_reg_m
`ifdef MEM_MISALIGN_TRAP_EN
    , misalign_m
`endif
  );
  modport master (
    output in_valid, reg_write_e, mem_read_e, mem_write_e, mem_unsigned_e, mem_size_e,
           alu_out_e, write_data_e, write_reg_e, dmem_ack, dmem_rdata,
    input in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
          out_valid, reg_write_m, timeout_m, result_m, write_reg_m
`ifdef MEM_MISALIGN_TRAP_EN
    , misalign_m
`endif
  );
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: registered MEM stage driving data memory via req/ack with watchdog; MEM_MISALIGN_TRAP_EN traps misaligned accesses
module mem_stage_hs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W = 5,
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic rst,
  mem_stage_hs_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [1:0] size, size_q;
  logic [LB-1:0] lane, lane_q;
  logic [ADDR_W-1:0] addr, amask;
  logic [NB-1:0] be;
  logic [DATA_W-1:0] wdata, sh, shl, sext, ext;
  logic [6:0] sa;
  logic uns_q, rw_q, accept, mem_op;
  // Decode the offered instruction: size folding, forced alignment, lane, store data and enables
  always_comb begin
    size = (DATA_W == 32 && bus.mem_size_e == 2'b11) ? 2'b10 : bus.mem_size_e;
    addr = ADDR_W'(bus.alu_out_e);
    amask = ADDR_W'((1 << size) - 1);
    lane = LB'(addr & ~amask);
    be = NB'((1 << (1 << size)) - 1) << lane;
    wdata = size == 2'd0 ? {NB{bus.write_data_e[7:0]}} :
            size == 2'd1 ? {NB/2{bus.write_data_e[15:0]}} :
            size == 2'd2 ? {DATA_W/32{bus.write_data_e[31:0]}} : bus.write_data_e;
    accept = bus.in_ready & bus.in_valid;
    mem_op = bus.mem_read_e | bus.mem_write_e;
  end
  // Pull the sized field out of the read word at the latched lane and extend it to full width
  always_comb begin
    sh = bus.dmem_rdata >> {lane_q, 3'b000};
    sa = 7'(DATA_W) - (7'd8 << size_q);
    shl = sh << sa;
    sext = $signed(shl) >>> sa;
    ext = uns_q ? shl >> sa : sext;
  end
  // IDLE/ACCESS control, memory request registers, watchdog and WB result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      size_q <= '0;
      lane_q <= '0;
      uns_q <= 1'b0;
      rw_q <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.dmem_req <= 1'b0;
      bus.dmem_we <= 1'b0;
      bus.dmem_addr <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_be <= '0;
      bus.out_valid <= 1'b0;
      bus.reg_write_m <= 1'b0;
      bus.timeout_m <= 1'b0;
      bus.result_m <= '0;
      bus.write_reg_m <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      bus.misalign_m <= 1'b0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      bus.timeout_m <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      bus.misalign_m <= 1'b0;
`endif
      if (state == IDLE) begin
        bus.in_ready <= 1'b1;
        if (accept) begin
          bus.write_reg_m <= bus.write_reg_e;
          bus.result_m <= bus.alu_out_e;
`ifdef MEM_MISALIGN_TRAP_EN
          if (mem_op && |(addr & amask)) begin
            bus.out_valid <= 1'b1;
            bus.reg_write_m <= 1'b0;
            bus.misalign_m <= 1'b1;
          end else
`endif
          if (mem_op) begin
            state <= ACCESS;
            cnt <= '0;
            bus.in_ready <= 1'b0;
            bus.dmem_req <= 1'b1;
            bus.dmem_we <= bus.mem_write_e;
            bus.dmem_addr <= addr & ~amask;
            bus.dmem_wdata <= wdata;
            bus.dmem_be <= be;
            size_q <= size;
            lane_q <= lane;
            uns_q <= bus.mem_unsigned_e;
            rw_q <= bus.reg_write_e & ~bus.mem_write_e;
          end else begin
            bus.out_valid <= 1'b1;
            bus.reg_write_m <= bus.reg_write_e;
          end
        end
      end else if (bus.dmem_ack) begin
        state <= IDLE;
        bus.in_ready <= 1'b1;
        bus.dmem_req <= 1'b0;
        bus.out_valid <= 1'b1;
        bus.result_m <= ext;
        bus.reg_write_m <= rw_q;
      end else if (cnt == CW'(MAX_WAIT - 1)) begin
        state <= IDLE;
        bus.in_ready <= 1'b1;
        bus.dmem_req <= 1'b0;
        bus.out_valid <= 1'b1;
        bus.timeout_m <= 1'b1;
        bus.reg_write_m <= 1'b0;
        bus.result_m <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
